npu_seq: RTL

NPU_SEQ -- requirements
Module: npu_seq

---
 rtl/npu_seq.sv | 132 +++++++++++++
 1 files changed

// File: rtl/npu_seq.sv
// NPU run sequencer: configures the NPU, streams image RAM addresses tile by
// tile, yields the memories to the host on request and drains the pipeline.
module npu_seq #(
    parameter int ADDR_W    = 10,
    parameter int DRAIN_CYC = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              host_wr,
    input  logic [7:0]        num_tiles,
    input  logic [3:0]        cfg_len,
    input  logic [7:0]        tile_len,
    output logic              EN_CONFIG,
    output logic              EN_FSM,
    output logic              SEL_CON,
    output logic [ADDR_W-1:0] image_ram_addr,
    output logic              host_gnt,
    output logic              busy,
    output logic              done,
    output logic [7:0]        tile_cnt
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CONFIG = 3'd1;
    localparam logic [2:0] S_RUN    = 3'd2;
    localparam logic [2:0] S_PAUSE  = 3'd3;
    localparam logic [2:0] S_DRAIN  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam int CYC_W = (DRAIN_CYC > 256) ? $clog2(DRAIN_CYC) : 8;

    logic [2:0]       state;
    logic [7:0]       num_l;
    logic [3:0]       cfg_l;
    logic [7:0]       tile_l;
    logic [CYC_W-1:0] cyc;

    logic [7:0]       cfg_last;
    logic [7:0]       tile_last;
    logic [CYC_W-1:0] drain_last;
    logic             tile_end;
    logic             last_tile;

    assign cfg_last   = (cfg_l == 4'd0) ? 8'd0 : {4'd0, cfg_l - 4'd1};
    // tile_len of 0 wraps to 255 here, giving a 256-cycle tile.
    assign tile_last  = tile_l - 8'd1;
    assign drain_last = CYC_W'(DRAIN_CYC - 1);
    assign tile_end   = (cyc == CYC_W'(tile_last));
    assign last_tile  = tile_end && ((tile_cnt + 8'd1) == num_l);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= S_IDLE;
            num_l          <= '0;
            cfg_l          <= '0;
            tile_l         <= '0;
            cyc            <= '0;
            tile_cnt       <= '0;
            image_ram_addr <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (num_tiles != 8'd0) begin
                            num_l          <= num_tiles;
                            cfg_l          <= cfg_len;
                            tile_l         <= tile_len;
                            cyc            <= '0;
                            tile_cnt       <= '0;
                            image_ram_addr <= '0;
                            state          <= S_CONFIG;
                        end else begin
                            state <= S_DONE;
                        end
                    end
                end
                S_CONFIG: begin
                    if (cyc == CYC_W'(cfg_last)) begin
                        cyc   <= '0;
                        state <= S_RUN;
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end
                S_RUN: begin
                    image_ram_addr <= image_ram_addr + 1'b1;
                    if (tile_end) begin
                        cyc      <= '0;
                        tile_cnt <= tile_cnt + 8'd1;
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                    // Completing the last tile outranks a host request.
                    if (last_tile) begin
                        state <= S_DRAIN;
                    end else if (host_wr) begin
                        state <= S_PAUSE;
                    end
                end
                S_PAUSE: begin
                    if (!host_wr) begin
                        state <= S_RUN;
                    end
                end
                S_DRAIN: begin
                    if (cyc == drain_last) begin
                        cyc   <= '0;
                        state <= S_DONE;
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign EN_CONFIG = (state == S_CONFIG);
    assign EN_FSM    = (state == S_RUN);
    assign SEL_CON   = (state == S_IDLE) || (state == S_CONFIG) || (state == S_DONE);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign host_gnt  = (state == S_PAUSE) ||
                       (((state == S_IDLE) || (state == S_DONE)) && host_wr);

endmodule
